// File: rtl/divider_pkg.sv
// Shared constants and helpers for the restoring divider family.
package divider_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // Bits needed to hold values 0..v-1; callers pass WIDTH+1 to size the iteration counter
  function automatic int clog2(input int v);
    int n;
    n = 0;
    while ((1 << n) < v) n++;
    return (n < 1) ? 1 : n;
  endfunction
endpackage

// File: rtl/trial_sub.sv
// Ripple subtract X - Y built as an adder with inverted Y and carry-in 1.
// Cout=1 means no borrow, i.e. X >= Y.
module trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic [W-1:0] D,
  output logic         Cout
);
  logic [W-1:0] w_yn;
  logic [W:0]   w_c;

  assign w_yn   = ~Y;
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign D[i]     = X[i] ^ w_yn[i] ^ w_c[i];
    assign w_c[i+1] = (X[i] & w_yn[i]) | (w_c[i] & (X[i] ^ w_yn[i]));
  end

  assign Cout = w_c[W];
endmodule

// File: rtl/restoring_divider_4.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
module restoring_divider_4
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);
  localparam int CNT_W = clog2(WIDTH + 1);

  logic [1:0]       r_state, w_state_nx;
  logic [WIDTH-1:0] r_dvd;   // dividend shifts out MSB-first, quotient bits fill from the LSB
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q, r_r;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem_sh, w_diff, w_rem_nx;
  logic [WIDTH-1:0] w_dvd_nx;
  logic             w_cout, w_last, w_accept;

  assign w_rem_sh = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};

  trial_sub #(.W(WIDTH + 1)) u_trial (
    .X    (w_rem_sh),
    .Y    ({1'b0, r_div}),
    .D    (w_diff),
    .Cout (w_cout)
  );

  assign w_rem_nx = w_cout ? w_diff : w_rem_sh;
  assign w_dvd_nx = {r_dvd[WIDTH-2:0], w_cout};
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = (B == '0) ? FINISH : RUN;
      RUN:     if (w_last) w_state_nx = FINISH;
      FINISH:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == FINISH);
  end

  // Datapath: operand capture, iteration, result load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_cnt <= '0;
      if (B == '0) begin
        // No iterations needed; result is defined directly
        r_q   <= '1;
        r_r   <= A;
        r_dbz <= 1'b1;
      end else begin
        r_dvd <= A;
        r_div <= B;
        r_q   <= '0;
        r_r   <= '0;
        r_dbz <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nx;
      r_dvd <= w_dvd_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_q <= w_dvd_nx;
        r_r <= w_rem_nx[WIDTH-1:0];
      end
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;
endmodule
